// File: rtl/mem_req_scheduler_pkg.sv
// Shared address-field layout and helpers for the scheduler and multi_bank_memory.
// Address = {bank[1:0], sub_bank[1:0], row[6:0]}.
package mem_req_scheduler_pkg;

   localparam int AW      = 11;
   localparam int DW      = 8;
   localparam int BANK_HI = 10;
   localparam int BANK_LO = 9;
   localparam int SUB_HI  = 8;
   localparam int SUB_LO  = 7;
   localparam int ROW_HI  = 6;
   localparam int SBID_W  = BANK_HI - SUB_LO + 1;
   localparam int ROW_W   = ROW_HI + 1;

   typedef logic [SBID_W-1:0] sbid_t;
   typedef logic [ROW_W-1:0]  row_t;

   typedef struct packed {
      logic rd;
      logic wr;
   } issue_t;

   // Global sub-bank id: two requests with equal ids contend for one array.
   function automatic sbid_t sbid_of(input logic [AW-1:0] a);
      return {a[BANK_HI:BANK_LO], a[SUB_HI:SUB_LO]};
   endfunction

   function automatic row_t row_of(input logic [AW-1:0] a);
      return a[ROW_HI:0];
   endfunction

endpackage

// File: rtl/mem_req_scheduler_wq_fifo.sv
// Circular write queue; exposes every slot's address and valid bit so the
// read path can detect read-after-write hazards against all pending writes.
module wq_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 11,
   parameter int DW    = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push_i,
   input  logic [AW-1:0]                 push_addr_i,
   input  logic [DW-1:0]                 push_data_i,
   input  logic                          pop_i,
   output logic [AW-1:0]                 head_addr_o,
   output logic [DW-1:0]                 head_data_o,
   output logic [$clog2(DEPTH):0]        count_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic [DEPTH-1:0][AW-1:0]      ent_addr_o,
   output logic [DEPTH-1:0]              ent_vld_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][AW-1:0] addr_q;
   logic [DEPTH-1:0][DW-1:0] data_q;
   logic [DEPTH-1:0]         vld_q, vld_d;
   logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]            count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      vld_d   = vld_q;
      if (push_i) begin
         tail_d        = tail_q + PW'(1);
         vld_d[tail_q] = 1'b1;
      end
      if (pop_i) begin
         head_d        = head_q + PW'(1);
         vld_d[head_q] = 1'b0;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
      end
   end

   // Payload storage needs no reset; the valid bits gate every use.
   always_ff @(posedge clk) begin
      if (push_i) begin
         addr_q[tail_q] <= push_addr_i;
         data_q[tail_q] <= push_data_i;
      end
   end

   assign head_addr_o = addr_q[head_q];
   assign head_data_o = data_q[head_q];
   assign count_o     = count_q;
   assign full_o      = (count_q == CW'(DEPTH));
   assign empty_o     = (count_q == '0);
   assign ent_addr_o  = addr_q;
   assign ent_vld_o   = vld_q;

endmodule

// File: rtl/mem_req_scheduler.sv
// Read/write request front-end for multi_bank_memory: queues writes, arbitrates
// same-sub-bank conflicts with a starvation bound, and returns read responses.
module mem_req_scheduler
   import mem_req_scheduler_pkg::*;
#(
   parameter int WQ_DEPTH   = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [AW-1:0]               wr_addr,
   input  logic [DW-1:0]               wr_data,
   input  logic                        rd_valid,
   output logic                        rd_ready,
   input  logic [AW-1:0]               rd_addr,
   output logic                        rsp_valid,
   output logic [DW-1:0]               rsp_data,
   output logic                        mem_ren,
   output logic                        mem_wen,
   output logic [AW-1:0]               mem_raddr,
   output logic [AW-1:0]               mem_waddr,
   output logic [DW-1:0]               mem_din,
   input  logic [DW-1:0]               mem_dout,
   output logic [$clog2(WQ_DEPTH):0]   wq_count
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [AW-1:0]                 head_addr;
   logic [DW-1:0]                 head_data;
   logic                          wq_full, wq_empty;
   logic [WQ_DEPTH-1:0][AW-1:0]   ent_addr;
   logic [WQ_DEPTH-1:0]           ent_vld;
   logic                          raw_hit, rd_cand, wr_cand, conflict, defer;
   issue_t                        iss;
   logic [SW-1:0]                 starve_q, starve_d;
   logic                          rsp_valid_q;

   wq_fifo #(.DEPTH(WQ_DEPTH), .AW(AW), .DW(DW)) u_wq (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (wr_valid & wr_ready),
      .push_addr_i (wr_addr),
      .push_data_i (wr_data),
      .pop_i       (iss.wr),
      .head_addr_o (head_addr),
      .head_data_o (head_data),
      .count_o     (wq_count),
      .full_o      (wq_full),
      .empty_o     (wq_empty),
      .ent_addr_o  (ent_addr),
      .ent_vld_o   (ent_vld)
   );

   always_comb begin
      raw_hit = 1'b0;
      for (int i = 0; i < WQ_DEPTH; i++)
         if (ent_vld[i] && ent_addr[i] == rd_addr) raw_hit = 1'b1;
   end

   assign rd_cand  = rd_valid & ~raw_hit;
   assign wr_cand  = ~wq_empty;
   assign conflict = sbid_of(rd_addr) == sbid_of(head_addr);

   // A full queue overrides the starvation budget so writers can always progress.
   always_comb begin
      iss   = '{rd: rd_cand, wr: wr_cand};
      defer = 1'b0;
      if (rd_cand && wr_cand && conflict) begin
         if (starve_q < SW'(STARVE_MAX) && !wq_full) begin
            iss   = '{rd: 1'b1, wr: 1'b0};
            defer = 1'b1;
         end else begin
            iss   = '{rd: 1'b0, wr: 1'b1};
         end
      end
   end

   always_comb begin
      starve_d = starve_q;
      if (iss.wr || wq_empty) starve_d = '0;
      else if (defer)         starve_d = starve_q + SW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q    <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         starve_q    <= starve_d;
         rsp_valid_q <= iss.rd;
      end
   end

   assign wr_ready  = ~wq_full;
   assign rd_ready  = iss.rd;
   assign mem_ren   = iss.rd;
   assign mem_wen   = iss.wr;
   assign mem_raddr = iss.rd ? rd_addr   : '0;
   assign mem_waddr = iss.wr ? head_addr : '0;
   assign mem_din   = iss.wr ? head_data : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_valid_q ? mem_dout : '0;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler with a behavioural 1-cycle-latency memory.
module tb_mem_req_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid, wr_ready, rd_valid, rd_ready;
   logic [10:0] wr_addr, rd_addr, mem_raddr, mem_waddr;
   logic [7:0]  wr_data, rsp_data, mem_din, mem_dout;
   logic        rsp_valid, mem_ren, mem_wen;
   logic [2:0]  wq_count;

   logic [7:0]  mem_arr [2048];
   int          total = 0;
   int          bad   = 0;
   logic [7:0]  rd5_exp [4] = '{8'h4A, 8'h4B, 8'h48, 8'h49};

   mem_req_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
      .mem_din(mem_din), .mem_dout(mem_dout), .wq_count(wq_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_ren) mem_dout <= mem_arr[mem_raddr];
      if (mem_wen) mem_arr[mem_waddr] <= mem_din;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      rd_valid = 1'b0; rd_addr = '0;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem_arr[i] = 8'(i) ^ 8'h5A;
      mem_dout = '0;
      rst_n = 1'b0;
      idle_in();
      repeat (2) step();
      chk("rst_count", wq_count, 0);
      chk("rst_rspv", rsp_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_wen", mem_wen, 0);
      step();

      // write then later read back
      wr_valid = 1'b1; wr_addr = 11'h0A5; wr_data = 8'h3C;
      @(negedge clk); chk("t1_wr_ready", wr_ready, 1);
      step();
      wr_valid = 1'b0;
      @(negedge clk);
      chk("t1_wen", mem_wen, 1);
      chk("t1_waddr", mem_waddr, 11'h0A5);
      chk("t1_din", mem_din, 8'h3C);
      chk("t1_count", wq_count, 1);
      step();
      @(negedge clk); chk("t1_count0", wq_count, 0);
      step();
      rd_valid = 1'b1; rd_addr = 11'h0A5;
      @(negedge clk);
      chk("t1_rd_ready", rd_ready, 1);
      chk("t1_raddr", mem_raddr, 11'h0A5);
      step();
      rd_valid = 1'b0;
      @(negedge clk);
      chk("t1_rspv", rsp_valid, 1);
      chk("t1_rspd", rsp_data, 8'h3C);
      step();

      // RAW: read right behind a write to the same address
      wr_valid = 1'b1; wr_addr = 11'h100; wr_data = 8'h77;
      step();
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 11'h100;
      @(negedge clk);
      chk("t2_rd_stall", rd_ready, 0);
      chk("t2_wen", mem_wen, 1);
      chk("t2_ren", mem_ren, 0);
      step();
      @(negedge clk);
      chk("t2_rd_go", rd_ready, 1);
      chk("t2_no_rsp", rsp_valid, 0);
      step();
      rd_valid = 1'b0;
      @(negedge clk);
      chk("t2_rspv", rsp_valid, 1);
      chk("t2_rspd", rsp_data, 8'h77);
      step();

      // different banks: read and write together
      wr_valid = 1'b1; wr_addr = 11'h200; wr_data = 8'h11;
      step();
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 11'h000;
      @(negedge clk);
      chk("t4_ren", mem_ren, 1);
      chk("t4_wen", mem_wen, 1);
      chk("t4_rd_ready", rd_ready, 1);
      chk("t4_waddr", mem_waddr, 11'h200);
      step();
      rd_valid = 1'b0;
      @(negedge clk);
      chk("t4_starve", dut.starve_q, 0);
      chk("t4_rspd", rsp_data, 8'h5A);
      step();

      // back-to-back reads
      for (int k = 0; k < 5; k++) begin
         if (k < 4) begin rd_valid = 1'b1; rd_addr = 11'h010 + 11'(k); end
         else rd_valid = 1'b0;
         @(negedge clk);
         if (k < 4) chk($sformatf("t5_rd_ready%0d", k), rd_ready, 1);
         if (k > 0) begin
            chk($sformatf("t5_rspv%0d", k), rsp_valid, 1);
            chk($sformatf("t5_rspd%0d", k), rsp_data, rd5_exp[k-1]);
         end
         step();
      end
      @(negedge clk); chk("t5_rsp_end", rsp_valid, 0);
      step();

      // starvation: reads hammer the head write's sub-bank
      rd_valid = 1'b1; rd_addr = 11'h080;
      for (int k = 0; k < 4; k++) begin
         wr_valid = 1'b1; wr_addr = 11'h081 + 11'(k); wr_data = 8'hA0 + 8'(k);
         @(negedge clk);
         chk($sformatf("t3_wr_ready%0d", k), wr_ready, 1);
         chk($sformatf("t3_rd_ready%0d", k), rd_ready, 1);
         chk($sformatf("t3_count%0d", k), wq_count, k);
         chk($sformatf("t3_starve%0d", k), dut.starve_q, (k == 0) ? 0 : k - 1);
         step();
      end
      wr_addr = 11'h085; wr_data = 8'hA4;
      @(negedge clk);
      chk("t3_full_wr_ready", wr_ready, 0);
      chk("t3_full_count", wq_count, 4);
      chk("t3_starve_max", dut.starve_q, 3);
      chk("t3_forced_rd_ready", rd_ready, 0);
      chk("t3_forced_wen", mem_wen, 1);
      chk("t3_forced_waddr", mem_waddr, 11'h081);
      chk("t3_forced_ren", mem_ren, 0);
      step();
      @(negedge clk);
      chk("t3_after_wr_ready", wr_ready, 1);
      chk("t3_after_count", wq_count, 3);
      chk("t3_after_rd_ready", rd_ready, 1);
      chk("t3_after_wen", mem_wen, 0);
      step();
      idle_in();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("t3_drain_waddr%0d", k), mem_waddr, 11'h082 + 11'(k));
         chk($sformatf("t3_drain_din%0d", k), mem_din, 8'hA1 + 8'(k));
         step();
      end
      @(negedge clk); chk("t3_drained", wq_count, 0);
      step();

      // reset mid-stream with queued writes and a read in flight
      rd_valid = 1'b1; rd_addr = 11'h180;
      for (int k = 0; k < 3; k++) begin
         wr_valid = 1'b1; wr_addr = 11'h181 + 11'(k); wr_data = 8'hC0 + 8'(k);
         step();
      end
      chk("t6_pre_count", wq_count, 3);
      chk("t6_pre_rspv", rsp_valid, 1);
      rst_n = 1'b0;
      idle_in();
      #1;
      chk("t6_rst_count", wq_count, 0);
      chk("t6_rst_rspv", rsp_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("t6_no_wen%0d", k), mem_wen, 0);
         chk($sformatf("t6_no_rsp%0d", k), rsp_valid, 0);
         chk($sformatf("t6_wr_ready%0d", k), wr_ready, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
